// File: rtl/core_dmem_responder.sv
// Data-memory responder: byte-strobed doubleword RAM behind the dmem_* handshake.
// Programmable wait states before grant; out-of-range accesses return an error.
module core_dmem_responder #(
    parameter int unsigned           MEM_ADDR_W  = 64,
    parameter int unsigned           MEM_DATA_W  = 64,
    parameter int unsigned           DEPTH       = 1024,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_CYCLES = 0
) (
    input  logic                    g_clk,
    input  logic                    g_reset,
    input  logic                    dmem_req,
    input  logic [MEM_ADDR_W-1:0]   dmem_addr,
    input  logic                    dmem_wen,
    input  logic [MEM_DATA_W/8-1:0] dmem_strb,
    input  logic [MEM_DATA_W-1:0]   dmem_wdata,
    output logic                    dmem_gnt,
    output logic                    dmem_err,
    output logic [MEM_DATA_W-1:0]   dmem_rdata
);

    localparam int NB    = MEM_DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    r_gnt;
    logic                    r_err;
    logic [MEM_DATA_W-1:0]   r_rdata;
    logic [MEM_DATA_W-1:0]   r_mem [DEPTH];

    logic [MEM_ADDR_W-1:0]   w_off;
    logic [MEM_ADDR_W-1:0]   w_word;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_in_range;
    logic                    w_access;
    logic                    w_we;

    // Address decode: word index relative to the RAM base and range check
    always_comb begin
        w_off      = dmem_addr - BASE_ADDR;
        w_word     = w_off >> OFF_W;
        w_idx      = w_word[IDX_W-1:0];
        w_in_range = (dmem_addr >= BASE_ADDR) &&
                     (w_word < MEM_ADDR_W'(DEPTH));
        w_access   = (r_state == S_GRANT);
        w_we       = w_access && dmem_wen && w_in_range;
    end

    // Next-state and wait-counter logic
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (dmem_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next = S_GRANT;
                    end else begin
                        w_cnt_next = WAIT_INIT;
                        w_next     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!dmem_req) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = S_GRANT;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_GRANT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, grant pulse and response registers
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_gnt   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_gnt   <= (w_next == S_GRANT);
            if (w_access) begin
                r_err <= !w_in_range;
                if (!w_in_range) begin
                    r_rdata <= '0;
                end else if (!dmem_wen) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Byte-strobed RAM write; contents are deliberately not reset
    always_ff @(posedge g_clk) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (dmem_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dmem_gnt   = r_gnt;
    assign dmem_err   = r_err;
    assign dmem_rdata = r_rdata;

endmodule

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder: two instances (no wait / base 0, and
// three waits / base 0x8000_0000) checked against an array memory model.
module tb_core_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic [63:0] addr  [2];
    logic        wen   [2];
    logic [7:0]  strb  [2];
    logic [63:0] wdata [2];
    logic        gnt   [2];
    logic        err   [2];
    logic [63:0] rdata [2];

    int ncmp = 0;
    int nfail = 0;

    logic [63:0] mem_m   [2][1024];
    logic [63:0] last_rd [2];
    logic        last_er [2];
    int          pool    [8] = '{0, 1, 2, 5, 100, 511, 1022, 1023};

    always #5 clk = ~clk;

    core_dmem_responder #(
        .MEM_ADDR_W(64), .MEM_DATA_W(64), .DEPTH(1024),
        .BASE_ADDR(64'h0), .WAIT_CYCLES(0)
    ) u_dut0 (
        .g_clk(clk), .g_reset(rst),
        .dmem_req(req[0]), .dmem_addr(addr[0]), .dmem_wen(wen[0]),
        .dmem_strb(strb[0]), .dmem_wdata(wdata[0]),
        .dmem_gnt(gnt[0]), .dmem_err(err[0]), .dmem_rdata(rdata[0])
    );

    core_dmem_responder #(
        .MEM_ADDR_W(64), .MEM_DATA_W(64), .DEPTH(1024),
        .BASE_ADDR(64'h8000_0000), .WAIT_CYCLES(3)
    ) u_dut1 (
        .g_clk(clk), .g_reset(rst),
        .dmem_req(req[1]), .dmem_addr(addr[1]), .dmem_wen(wen[1]),
        .dmem_strb(strb[1]), .dmem_wdata(wdata[1]),
        .dmem_gnt(gnt[1]), .dmem_err(err[1]), .dmem_rdata(rdata[1])
    );

    function automatic logic [63:0] base_of(input int b);
        return (b == 0) ? 64'h0 : 64'h8000_0000;
    endfunction

    function automatic int wait_of(input int b);
        return (b == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] o,
                         input logic [63:0] e);
        ncmp++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, o, e);
        end
    endtask

    task automatic do_access(input int b, input logic [63:0] a,
                             input logic w, input logic [7:0] s,
                             input logic [63:0] d, input string tag);
        int          cyc;
        bit          got;
        bit          inr;
        logic [63:0] idx;
        logic [63:0] exp_rd;
        logic        exp_er;
        idx = (a - base_of(b)) >> 3;
        inr = (a >= base_of(b)) && (idx < 64'd1024);
        @(negedge clk);
        req[b] = 1'b1; addr[b] = a; wen[b] = w;
        strb[b] = s; wdata[b] = d;
        cyc = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt[b]) got = 1;
        end
        check({tag, " latency"}, 64'(cyc), 64'(wait_of(b) + 1));
        req[b] = 1'b0;
        @(negedge clk);
        if (!inr) begin
            exp_rd = 64'h0;
            exp_er = 1'b1;
        end else if (w) begin
            for (int i = 0; i < 8; i++)
                if (s[i]) mem_m[b][idx[9:0]][8*i +: 8] = d[8*i +: 8];
            exp_rd = last_rd[b];
            exp_er = 1'b0;
        end else begin
            exp_rd = mem_m[b][idx[9:0]];
            exp_er = 1'b0;
        end
        last_rd[b] = exp_rd;
        last_er[b] = exp_er;
        check({tag, " rdata"}, rdata[b], exp_rd);
        check({tag, " err"}, 64'(err[b]), 64'(exp_er));
        check({tag, " gnt pulse"}, 64'(gnt[b]), 64'h0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] old5;
        int          b;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; addr[i] = 0; wen[i] = 0; strb[i] = 0; wdata[i] = 0;
            last_rd[i] = 0; last_er[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset gnt", 64'(gnt[i]), 64'h0);
            check("reset err", 64'(err[i]), 64'h0);
            check("reset rdata", rdata[i], 64'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++)
                do_access(i, base_of(i) + 64'(pool[j] * 8), 1'b1, 8'hFF,
                          {$urandom, $urandom}, "init");

        do_access(0, 64'h10, 1'b1, 8'hFF, 64'h1122334455667788, "st10");
        do_access(0, 64'h10, 1'b0, 8'h00, 64'h0, "ld10");
        check("ld10 const", rdata[0], 64'h1122334455667788);
        do_access(0, 64'h10, 1'b1, 8'h0C, 64'h0000_0000_AABB_0000, "st10 strb");
        do_access(0, 64'h13, 1'b0, 8'h00, 64'h0, "ld13");
        check("ld13 const", rdata[0], 64'h11223344AABB7788);
        do_access(0, 64'h08, 1'b1, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, "st strb0");
        do_access(0, 64'h0F, 1'b0, 8'h00, 64'h0, "ld strb0");

        @(negedge clk);
        req[0] = 1'b1; addr[0] = 64'h10; wen[0] = 1'b0; strb[0] = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("b2b gnt c%0d", k), 64'(gnt[0]), 64'(k % 2));
            if (k == 5) req[0] = 1'b0;
        end
        @(negedge clk);
        check("b2b gnt c6", 64'(gnt[0]), 64'h0);
        check("b2b rdata", rdata[0], mem_m[0][2]);
        last_rd[0] = mem_m[0][2];
        last_er[0] = 1'b0;

        do_access(1, 64'h8000_2000, 1'b0, 8'h00, 64'h0, "oor hi");
        check("oor hi err const", 64'(err[1]), 64'h1);
        do_access(1, 64'h7FFF_FFF8, 1'b0, 8'h00, 64'h0, "oor lo");
        check("oor lo rdata const", rdata[1], 64'h0);
        do_access(1, 64'h8000_2000, 1'b1, 8'hFF, 64'hFFFF_0000_FFFF_0000, "oor st");
        for (int j = 0; j < 8; j++)
            do_access(1, 64'h8000_0000 + 64'(pool[j] * 8), 1'b0, 8'h00, 64'h0,
                      $sformatf("post oor ld %0d", pool[j]));

        old5 = mem_m[1][5];
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 64'h8000_0028; wen[1] = 1'b1;
        strb[1] = 8'hFF; wdata[1] = ~old5;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check($sformatf("abandon gnt c%0d", k), 64'(gnt[1]), 64'h0);
        end
        req[1] = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("abandon gnt c%0d", k), 64'(gnt[1]), 64'h0);
        end
        do_access(1, 64'h8000_0028, 1'b0, 8'h00, 64'h0, "abandon ld");
        check("abandon ld old", rdata[1], old5);

        @(negedge clk);
        req[1] = 1'b1; addr[1] = 64'h8000_0028; wen[1] = 1'b1;
        strb[1] = 8'hFF; wdata[1] = ~old5;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst mid gnt", 64'(gnt[1]), 64'h0);
        check("rst mid err", 64'(err[1]), 64'h0);
        check("rst mid rdata", rdata[1], 64'h0);
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_rd[i] = 0; last_er[i] = 0;
        end
        do_access(1, 64'h8000_0028, 1'b0, 8'h00, 64'h0, "rst ld");
        check("rst ld old", rdata[1], old5);

        for (int n = 0; n < 60; n++) begin
            b = $urandom_range(0, 1);
            if ($urandom_range(0, 4) != 0)
                a = base_of(b) + 64'(pool[$urandom_range(0, 7)] * 8)
                    + 64'($urandom_range(0, 7));
            else if (b == 1 && $urandom_range(0, 1) == 0)
                a = base_of(b) - 64'($urandom_range(1, 64));
            else
                a = base_of(b) + 64'h2000 + 64'($urandom_range(0, 4095) * 8);
            do_access(b, a, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                      {$urandom, $urandom}, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
